// File: rtl/io_pkg.sv
// Shared definitions for the CPU byte I/O path: transmit FSM states and UART 8N1 frame constants.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // 868 clocks per bit gives 115200 baud from a 100 MHz clock.
    localparam int unsigned CLK_PER_BIT_DEFAULT = 868;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned STOP_BITS  = 1;
    localparam int unsigned FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

endpackage

// File: rtl/out_fifo.sv
// Synchronous FIFO that queues output bytes ahead of the UART serialiser.
module out_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push_acc;
    logic             w_pop_acc;

    assign full       = (r_count == CNT_W'(DEPTH));
    assign empty      = (r_count == '0);
    assign w_push_acc = push && !full;
    assign w_pop_acc  = pop && !empty;
    assign dout       = r_mem[r_rd_ptr];
    assign count      = r_count;

    // Pointers wrap naturally; count tracks occupancy so full and empty are unambiguous.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/output_tx_unit.sv
// Transmit end of the CPU byte I/O path: buffers output bytes and sends them as UART 8N1 frames.
// Define OUTPUT_TX_FIFO_EN for a 2**FIFO_DEPTH_LOG2 FIFO buffer; otherwise a single holding register.
module output_tx_unit
    import io_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT     = CLK_PER_BIT_DEFAULT,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       out_valid,
    input  logic [7:0] out_data,
    output logic       out_ready,
    output logic       txd,
    output logic       tx_busy,
    output logic       overflow
);

    localparam int unsigned BAUD_W = $clog2(CLK_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t         r_state;
    tx_state_t         w_state_next;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baud_next;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_idx_next;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_next;
    logic              r_txd;
    logic              w_txd_next;
    logic              r_tx_busy;
    logic              r_out_ready;
    logic              r_overflow;
    logic              w_baud_end;
    logic              w_pop;
    logic              w_push_acc;
    logic              w_buf_full;
    logic              w_buf_empty;
    logic              w_buf_empty_next;
    logic              w_out_ready_next;
    logic [7:0]        w_head;

    assign w_push_acc = out_valid && !w_buf_full;
    assign w_baud_end = (r_baud == BAUD_LAST);

`ifdef OUTPUT_TX_FIFO_EN
    localparam int unsigned CNT_W      = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned FIFO_DEPTH = 2 ** FIFO_DEPTH_LOG2;

    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_count_next;
    logic [CNT_W-1:0] w_free_next;

    out_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (DATA_BITS)
    ) u_out_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (out_valid),
        .pop   (w_pop),
        .din   (out_data),
        .dout  (w_head),
        .count (w_count),
        .full  (w_buf_full),
        .empty (w_buf_empty)
    );

    // Occupancy after this edge's push/pop, so out_ready covers E plus the instruction in D.
    always_comb begin
        w_count_next = w_count;
        if (w_push_acc && !w_pop) begin
            w_count_next = w_count + CNT_W'(1);
        end else if (!w_push_acc && w_pop) begin
            w_count_next = w_count - CNT_W'(1);
        end
    end

    assign w_free_next      = CNT_W'(FIFO_DEPTH) - w_count_next;
    assign w_buf_empty_next = (w_count_next == '0);
    assign w_out_ready_next = (w_free_next >= CNT_W'(2));
`else
    logic       r_hold_valid;
    logic       w_hold_valid_next;
    logic [7:0] r_hold_data;

    assign w_buf_full        = r_hold_valid;
    assign w_buf_empty       = !r_hold_valid;
    assign w_head            = r_hold_data;
    assign w_hold_valid_next = w_push_acc || (r_hold_valid && !w_pop);
    assign w_buf_empty_next  = !w_hold_valid_next;
    // A write in flight this cycle will occupy the register, so withhold ready for it too.
    assign w_out_ready_next  = !w_hold_valid_next && !out_valid;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else begin
            r_hold_valid <= w_hold_valid_next;
            if (w_push_acc) begin
                r_hold_data <= out_data;
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; the stop bit chains directly into the next start bit when data waits.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (!w_buf_empty) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (w_baud_end) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_baud_end && (r_bit_idx == LAST_BIT)) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_baud_end) begin
                    w_state_next = w_buf_empty ? IDLE : START;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath control: pops, baud counting, shifting and the next line level.
    always_comb begin
        w_pop          = 1'b0;
        w_baud_next    = '0;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_txd_next     = 1'b1;
        case (r_state)
            IDLE: begin
                if (!w_buf_empty) begin
                    w_pop          = 1'b1;
                    w_shift_next   = w_head;
                    w_bit_idx_next = '0;
                end
            end
            START: begin
                w_baud_next = w_baud_end ? '0 : r_baud + BAUD_W'(1);
                if (w_baud_end) begin
                    w_bit_idx_next = '0;
                end
            end
            DATA: begin
                w_baud_next = w_baud_end ? '0 : r_baud + BAUD_W'(1);
                if (w_baud_end) begin
                    w_shift_next   = r_shift >> 1;
                    w_bit_idx_next = r_bit_idx + 3'(1);
                end
            end
            STOP: begin
                w_baud_next = w_baud_end ? '0 : r_baud + BAUD_W'(1);
                if (w_baud_end && !w_buf_empty) begin
                    w_pop          = 1'b1;
                    w_shift_next   = w_head;
                    w_bit_idx_next = '0;
                end
            end
            default: w_baud_next = '0;
        endcase
        case (w_state_next)
            START:   w_txd_next = 1'b0;
            DATA:    w_txd_next = w_shift_next[0];
            default: w_txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_baud      <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_txd       <= 1'b1;
            r_tx_busy   <= 1'b0;
            r_out_ready <= 1'b1;
            r_overflow  <= 1'b0;
        end else begin
            r_baud      <= w_baud_next;
            r_bit_idx   <= w_bit_idx_next;
            r_shift     <= w_shift_next;
            r_txd       <= w_txd_next;
            r_tx_busy   <= (w_state_next != IDLE) || !w_buf_empty_next;
            r_out_ready <= w_out_ready_next;
            // A write into a full buffer is lost even if the head is popped on the same edge.
            r_overflow  <= r_overflow || (out_valid && w_buf_full);
        end
    end

    assign txd       = r_txd;
    assign tx_busy   = r_tx_busy;
    assign out_ready = r_out_ready;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_output_tx_unit.sv
// Self-checking bench for output_tx_unit against a frame-level reference model (CLK_PER_BIT=4).
`timescale 1ns/1ps
module tb_output_tx_unit;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
`ifdef OUTPUT_TX_FIFO_EN
    localparam int CAP       = 16;
    localparam bit FIFO_MODE = 1'b1;
`else
    localparam int CAP       = 1;
    localparam bit FIFO_MODE = 1'b0;
`endif

    logic       clk       = 1'b0;
    logic       rstn      = 1'b0;
    logic       out_valid = 1'b0;
    logic [7:0] out_data  = 8'h00;
    logic       out_ready;
    logic       txd;
    logic       tx_busy;
    logic       overflow;

    output_tx_unit #(
        .CLK_PER_BIT     (CPB),
        .FIFO_DEPTH_LOG2 (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .txd       (txd),
        .tx_busy   (tx_busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endfunction

    // Line level at a given cycle offset into a frame carrying byte b.
    function automatic logic frame_bit(logic [7:0] b, int pos);
        int k;
        k = pos / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    // Reference model: a byte queue plus the position inside the frame on the line.
    logic [7:0] mq[$];
    logic [7:0] m_sent[$];
    logic [7:0] dec_bytes[$];
    bit         m_in_frame = 1'b0;
    int         m_pos      = 0;
    logic [7:0] m_cur      = 8'h00;
    bit         m_ovf      = 1'b0;
    bit         m_ready    = 1'b1;
    bit         started    = 1'b0;
    bit         dec_active = 1'b0;
    int         dec_cnt    = 0;
    logic [7:0] dec_byte   = 8'h00;
    logic       prev_txd   = 1'b1;

    always @(posedge clk) begin
        bit         v;
        bit         rs;
        bit         do_pop;
        bit         full;
        logic [7:0] d;
        v  = out_valid;
        d  = out_data;
        rs = rstn;
        if (!rs) begin
            mq.delete();
            m_in_frame = 1'b0;
            m_pos      = 0;
            m_ovf      = 1'b0;
            m_ready    = 1'b1;
            started    = 1'b1;
        end else if (started) begin
            do_pop = (mq.size() > 0) && (!m_in_frame || m_pos == FRAME - 1);
            full   = (mq.size() == CAP);
            if (m_in_frame && m_pos == FRAME - 1) begin
                m_sent.push_back(m_cur);
                m_in_frame = 1'b0;
            end else if (m_in_frame) begin
                m_pos++;
            end
            if (do_pop) begin
                m_cur      = mq.pop_front();
                m_in_frame = 1'b1;
                m_pos      = 0;
            end
            if (v) begin
                if (full) m_ovf = 1'b1;
                else mq.push_back(d);
            end
            m_ready = FIFO_MODE ? ((CAP - mq.size()) >= 2) : (mq.size() == 0 && !v);
        end
        #1;
        if (started) begin
            chk("txd", txd, m_in_frame ? frame_bit(m_cur, m_pos) : 1'b1);
            chk("tx_busy", tx_busy, m_in_frame || (mq.size() > 0));
            chk("out_ready", out_ready, m_ready);
            chk("overflow", overflow, m_ovf);
            // Independent UART receiver sampling mid-bit.
            if (!rs) begin
                dec_active = 1'b0;
            end else if (!dec_active) begin
                if (prev_txd === 1'b1 && txd === 1'b0) begin
                    dec_active = 1'b1;
                    dec_cnt    = 0;
                end
            end else begin
                dec_cnt++;
            end
            if (dec_active) begin
                if (dec_cnt >= CPB && dec_cnt < 9 * CPB && (dec_cnt % CPB) == CPB / 2)
                    dec_byte[dec_cnt / CPB - 1] = txd;
                if (dec_cnt == 9 * CPB + CPB / 2) begin
                    dec_bytes.push_back(dec_byte);
                    dec_active = 1'b0;
                end
            end
            prev_txd = txd;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rstn      = 1'b0;
        out_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic burst(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int n);
        logic [7:0] bytes [3];
        bytes[0] = b0;
        bytes[1] = b1;
        bytes[2] = b2;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            out_valid = 1'b1;
            out_data  = bytes[i];
        end
        @(negedge clk);
        out_valid = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string name);
        int c;
        c = 0;
        while (tx_busy !== 1'b0 && c < maxc) begin
            @(negedge clk);
            c++;
        end
        chk({name, "_drain"}, tx_busy, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] a5_frame;
        int         base;
        a5_frame = 10'b1_1010_0101_0;

        // Reset and idle hold.
        do_reset();
        repeat (20) @(negedge clk);
        chk("idle_txd", txd, 1'b1);
        chk("idle_ready", out_ready, 1'b1);
        chk("idle_busy", tx_busy, 1'b0);
        chk("idle_ovf", overflow, 1'b0);

        // Single 0xA5 frame, one cycle from write to start bit.
        burst(8'hA5, 8'h00, 8'h00, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < FRAME; i++) begin
            chk("a5_frame", txd, a5_frame[i / CPB]);
            if (i == 0) chk("a5_busy", tx_busy, 1'b1);
            @(posedge clk);
            #1;
        end
        chk("a5_busy_end", tx_busy, 1'b0);

        // Three consecutive writes.
        do_reset();
        base = dec_bytes.size();
        burst(8'h00, 8'hFF, 8'h3C, 3);
        wait_idle(500, "three");
        chk("three_count", dec_bytes.size() - base, FIFO_MODE ? 3 : 2);
        chk("three_ovf", overflow, FIFO_MODE ? 1'b0 : 1'b1);
        if (dec_bytes.size() >= base + 2) begin
            chk("three_b0", dec_bytes[base], 8'h00);
            chk("three_b1", dec_bytes[base+1], FIFO_MODE ? 8'hFF : 8'h3C);
        end

        // Twenty consecutive writes overrun the buffer.
        do_reset();
        base = dec_bytes.size();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            out_valid = 1'b1;
            out_data  = 8'(8'h10 + i);
        end
        @(negedge clk);
        out_valid = 1'b0;
        chk("burst_ovf", overflow, 1'b1);
        wait_idle(2000, "burst");
        chk("burst_ovf_sticky", overflow, 1'b1);
        chk("burst_count", dec_bytes.size() - base, FIFO_MODE ? 17 : 2);
        if (dec_bytes.size() > base)
            chk("burst_last", dec_bytes[dec_bytes.size()-1], FIFO_MODE ? 8'h20 : 8'h12);

        // Second write one cycle after the first.
        do_reset();
        @(negedge clk);
        out_valid = 1'b1;
        out_data  = 8'h11;
        @(negedge clk);
        chk("pair_ready0", out_ready, FIFO_MODE ? 1'b1 : 1'b0);
        out_data = 8'h22;
        @(negedge clk);
        out_valid = 1'b0;
        chk("pair_ready1", out_ready, FIFO_MODE ? 1'b1 : 1'b0);
        chk("pair_ovf", overflow, FIFO_MODE ? 1'b0 : 1'b1);
        wait_idle(500, "pair");

        // Reset during data bit 3 of 0x55 with bytes queued.
        do_reset();
        base = dec_bytes.size();
        burst(8'h55, 8'h66, 8'h77, 3);
        repeat (15) @(negedge clk);
        chk("mid_bit3", txd, 1'b0);
        rstn = 1'b0;
        @(negedge clk);
        chk("mid_txd", txd, 1'b1);
        chk("mid_busy", tx_busy, 1'b0);
        chk("mid_ovf", overflow, 1'b0);
        rstn = 1'b1;
        repeat (60) @(negedge clk);
        chk("mid_after_txd", txd, 1'b1);
        chk("mid_after_busy", tx_busy, 1'b0);
        chk("mid_after_count", dec_bytes.size() - base, 0);

        // Randomised traffic: first honouring out_ready, then ignoring it.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i < 1500) out_valid = out_ready && ($urandom_range(0, 99) < 60);
            else out_valid = ($urandom_range(0, 99) < 15);
            out_data = 8'($urandom);
        end
        @(negedge clk);
        out_valid = 1'b0;
        wait_idle(20000, "random");
        repeat (5) @(negedge clk);

        // Everything the model sent must appear on the line in order.
        chk("sent_count", dec_bytes.size(), m_sent.size());
        for (int i = 0; i < m_sent.size() && i < dec_bytes.size(); i++)
            chk("sent_byte", dec_bytes[i], m_sent[i]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
